// File: rtl/pbit_sampler_pkg.sv
// Shared definitions for the p-bit sampler: FSM state encoding and the
// per-bit count width helper (a window of 2^winLog2 samples needs winLog2+1 bits).
package pbit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCUM  = 2'd2,
    HOLD   = 2'd3
  } state_e;

  function automatic int cnt_width(input int winLog2);
    return winLog2 + 1;
  endfunction

endpackage

// File: rtl/pbit_sampler_if.sv
// Handshake/result bundle of the p-bit sampler, shared by the sampler's
// environment (master drives start/en/pbit_in/res_ready) and the sampler (slave).
interface pbit_sampler_if #(
  parameter int NBITS    = 8,
  parameter int WIN_LOG2 = 10
);

  logic                            start;
  logic                            en;
  logic [NBITS-1:0]                pbit_in;
  logic                            busy;
  logic                            res_valid;
  logic                            res_ready;
  logic [NBITS*(WIN_LOG2+1)-1:0]   ones_cnt;
  logic [NBITS-1:0]                mode_vec;

  modport master (
    output start, en, pbit_in, res_ready,
    input  busy, res_valid, ones_cnt, mode_vec
  );

  modport slave (
    input  start, en, pbit_in, res_ready,
    output busy, res_valid, ones_cnt, mode_vec
  );

endinterface

// File: rtl/pbit_sampler_ones_counter.sv
// Ones counter for a single p-bit: synchronous clear, qualified increment, hold.
// The majority flag is registered alongside the count so both change together.
module pbit_ones_counter
  import pbit_pkg::*;
#(
  parameter int WIN_LOG2 = 10
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             clr_i,
  input  logic                             inc_i,
  output logic [cnt_width(WIN_LOG2)-1:0]   cnt_o,
  output logic                             mode_o
);

  localparam int CW = cnt_width(WIN_LOG2);
  // Half a window; reaching it exactly counts as a majority (tie goes to 1).
  localparam logic [CW-1:0] HALF = CW'(1) << (WIN_LOG2 - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CW'(1);
    end
    mode_d = (cnt_d >= HALF);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign mode_o = mode_q;

endmodule

// File: rtl/pbit_sampler.sv
// P-bit sampler: counts ones per p-bit over a window of qualified samples and
// holds the result for a ready/valid consumer. PBIT_SAMPLER_BURNIN_EN adds a burn-in phase.
module pbit_sampler
  import pbit_pkg::*;
#(
  parameter int NBITS    = 8,
  parameter int WIN_LOG2 = 10,
  parameter int BURN_IN  = 16
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            start,
  input  logic                            en,
  input  logic [NBITS-1:0]                pbit_in,
  output logic                            busy,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [NBITS*(WIN_LOG2+1)-1:0]   ones_cnt,
  output logic [NBITS-1:0]                mode_vec
);

  localparam int CW = cnt_width(WIN_LOG2);

  state_e              state_q, state_d;
  logic [WIN_LOG2-1:0] idx_q, idx_d;
  logic                clrCnt;
  logic                incEn;

`ifdef PBIT_SAMPLER_BURNIN_EN
  localparam int BW = (BURN_IN > 1) ? $clog2(BURN_IN) : 1;
  logic [BW-1:0] burn_q, burn_d;
`else
  logic unusedBurnIn;
  assign unusedBurnIn = (BURN_IN != 0);
`endif

  // Counters are cleared only on the edge that enters ACCUM, so the previous
  // result stays visible through IDLE (and SETTLE) until a new window starts.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clrCnt  = 1'b0;
    incEn   = 1'b0;
`ifdef PBIT_SAMPLER_BURNIN_EN
    burn_d  = burn_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef PBIT_SAMPLER_BURNIN_EN
          if (BURN_IN > 0) begin
            state_d = SETTLE;
            burn_d  = '0;
          end else begin
            state_d = ACCUM;
            clrCnt  = 1'b1;
            idx_d   = '0;
          end
`else
          state_d = ACCUM;
          clrCnt  = 1'b1;
          idx_d   = '0;
`endif
        end
      end
`ifdef PBIT_SAMPLER_BURNIN_EN
      SETTLE: begin
        if (en) begin
          if (burn_q == BW'(BURN_IN - 1)) begin
            state_d = ACCUM;
            clrCnt  = 1'b1;
            idx_d   = '0;
          end else begin
            burn_d = burn_q + BW'(1);
          end
        end
      end
`endif
      ACCUM: begin
        if (en) begin
          incEn = 1'b1;
          idx_d = idx_q + WIN_LOG2'(1);
          if (idx_q == '1) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
`ifdef PBIT_SAMPLER_BURNIN_EN
      burn_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
`ifdef PBIT_SAMPLER_BURNIN_EN
      burn_q  <= burn_d;
`endif
    end
  end

  assign busy      = (state_q == SETTLE) || (state_q == ACCUM);
  assign res_valid = (state_q == HOLD);

  for (genvar i = 0; i < NBITS; i++) begin : g_bit
    pbit_ones_counter #(
      .WIN_LOG2(WIN_LOG2)
    ) u_cnt (
      .CLK    (CLK),
      .RST    (RST),
      .clr_i  (clrCnt),
      .inc_i  (incEn & pbit_in[i]),
      .cnt_o  (ones_cnt[i*CW +: CW]),
      .mode_o (mode_vec[i])
    );
  end

endmodule

// File: tb/tb_pbit_sampler.sv
// Scoreboard bench for pbit_sampler (NBITS=4, WIN_LOG2=3, BURN_IN=2); expectations
// adapt to PBIT_SAMPLER_BURNIN_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_pbit_sampler;

  localparam int NBITS    = 4;
  localparam int WIN_LOG2 = 3;
  localparam int BURN_IN  = 2;
  localparam int CW       = WIN_LOG2 + 1;
  localparam int WIN      = 1 << WIN_LOG2;
`ifdef PBIT_SAMPLER_BURNIN_EN
  localparam int BURN_MODEL = BURN_IN;
`else
  localparam int BURN_MODEL = 0;
`endif

  typedef struct packed {
    logic [NBITS*CW-1:0] cnt;
    logic [NBITS-1:0]    mode;
  } result_t;

  result_t expQ[$];
  result_t lastRes;
  logic    CLK;
  logic    RST;
  int      assertCount;
  int      failCount;
  int      cycFromStart;

  pbit_sampler_if #(.NBITS(NBITS), .WIN_LOG2(WIN_LOG2)) bus();

  pbit_sampler #(
    .NBITS(NBITS), .WIN_LOG2(WIN_LOG2), .BURN_IN(BURN_IN)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (bus.start),
    .en        (bus.en),
    .pbit_in   (bus.pbit_in),
    .busy      (bus.busy),
    .res_valid (bus.res_valid),
    .res_ready (bus.res_ready),
    .ones_cnt  (bus.ones_cnt),
    .mode_vec  (bus.mode_vec)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [NBITS-1:0] patternFor(input int kind, input int q);
    case (kind)
      0:       return 4'b1010;
      1:       return (q % 2 == 0) ? 4'b0001 : 4'b0000;
      2:       return 4'b1111;
      default: return (q < 2) ? 4'b1111 : 4'b0000;
    endcase
  endfunction

  // Starts a run, drives one window of samples and pushes the model's result.
  // Non-qualified cycles carry the inverted pattern, which must not be counted.
  task automatic applyStimulus(input int kind, input int period, input logic readyDuring);
    int               q;
    int               acc;
    int               expCnt[NBITS];
    logic [NBITS-1:0] p;
    logic             e;
    result_t          res;
    for (int i = 0; i < NBITS; i++) expCnt[i] = 0;
    q = 0;
    acc = 0;
    bus.start = 1'b1;
    bus.en = 1'b0;
    bus.pbit_in = '0;
    bus.res_ready = readyDuring;
    @(posedge CLK); #1;
    bus.start = 1'b0;
    cycFromStart = 1;
    checkOutput("busyAfterStart", 32'(bus.busy), 32'd1);
    while (acc < WIN) begin
      e = (((cycFromStart - 1) % period) == 0);
      p = patternFor(kind, q);
      bus.en = e;
      bus.pbit_in = e ? p : ~p;
      if (e) begin
        if (q >= BURN_MODEL) begin
          acc++;
          for (int i = 0; i < NBITS; i++) if (p[i]) expCnt[i]++;
        end
        q++;
      end
      @(posedge CLK); #1;
      cycFromStart++;
    end
    bus.en = 1'b0;
    bus.pbit_in = '0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < NBITS; i++) begin
      res.cnt[i*CW +: CW] = CW'(expCnt[i]);
      res.mode[i] = (expCnt[i] >= WIN / 2);
    end
    expQ.push_back(res);
  endtask

  task automatic checkResult(input string tag, input int expLatency);
    int      guard;
    result_t res;
    guard = 0;
    while (bus.res_valid !== 1'b1 && guard < 40) begin
      @(posedge CLK); #1;
      cycFromStart++;
      guard++;
    end
    checkOutput({tag, "_resValid"}, 32'(bus.res_valid), 32'd1);
    checkOutput({tag, "_latency"}, 32'(cycFromStart), 32'(expLatency));
    checkOutput({tag, "_busyHold"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, "_sbDepth"}, 32'(expQ.size()), 32'd1);
    if (expQ.size() > 0) begin
      res = expQ.pop_front();
      lastRes = res;
      checkOutput({tag, "_onesCnt"}, 32'(bus.ones_cnt), 32'(res.cnt));
      checkOutput({tag, "_modeVec"}, 32'(bus.mode_vec), 32'(res.mode));
    end
  endtask

  task automatic acceptResult(input logic withStart);
    bus.res_ready = 1'b1;
    bus.start = withStart;
    @(posedge CLK); #1;
    bus.res_ready = 1'b0;
    bus.start = 1'b0;
    checkOutput("resValidAfterAccept", 32'(bus.res_valid), 32'd0);
    checkOutput("busyAfterAccept", 32'(bus.busy), 32'd0);
    @(posedge CLK); #1;
    checkOutput("busyIdle", 32'(bus.busy), 32'd0);
    checkOutput("retainCnt", 32'(bus.ones_cnt), 32'(lastRes.cnt));
    checkOutput("retainMode", 32'(bus.mode_vec), 32'(lastRes.mode));
  endtask

  initial begin
    assertCount = 0;
    failCount = 0;
    cycFromStart = 0;
    lastRes = '0;
    RST = 1'b0;
    bus.start = 1'b0;
    bus.en = 1'b0;
    bus.pbit_in = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("rstBusy", 32'(bus.busy), 32'd0);
    checkOutput("rstValid", 32'(bus.res_valid), 32'd0);
    checkOutput("rstCnt", 32'(bus.ones_cnt), 32'd0);
    checkOutput("rstMode", 32'(bus.mode_vec), 32'd0);
    RST = 1'b1;
    @(posedge CLK); #1;

    $display("[TB] constant pattern, en every cycle");
    applyStimulus(0, 1, 1'b0);
    checkResult("constEn1", 9 + BURN_MODEL);
    acceptResult(1'b0);

    $display("[TB] constant pattern, en every other cycle");
    applyStimulus(0, 2, 1'b0);
    checkResult("constEn2", 16 + 2 * BURN_MODEL);
    acceptResult(1'b0);

    $display("[TB] alternating bit0 tie, res_ready held high during the run");
    applyStimulus(1, 1, 1'b1);
    checkResult("tie", 9 + BURN_MODEL);
    acceptResult(1'b0);

    $display("[TB] hold stability with start pulsed in HOLD");
    applyStimulus(2, 1, 1'b0);
    checkResult("allOnes", 9 + BURN_MODEL);
    for (int c = 0; c < 5; c++) begin
      bus.start = (c == 2);
      @(posedge CLK); #1;
      bus.start = 1'b0;
      checkOutput("holdValid", 32'(bus.res_valid), 32'd1);
      checkOutput("holdBusy", 32'(bus.busy), 32'd0);
      checkOutput("holdCnt", 32'(bus.ones_cnt), 32'(lastRes.cnt));
      checkOutput("holdMode", 32'(bus.mode_vec), 32'(lastRes.mode));
    end
    acceptResult(1'b1);

    $display("[TB] reset in the middle of a run");
    bus.start = 1'b1;
    bus.en = 1'b1;
    bus.pbit_in = 4'b1010;
    @(posedge CLK); #1;
    bus.start = 1'b0;
    repeat (BURN_MODEL + 3) @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    checkOutput("midRstBusy", 32'(bus.busy), 32'd0);
    checkOutput("midRstValid", 32'(bus.res_valid), 32'd0);
    checkOutput("midRstCnt", 32'(bus.ones_cnt), 32'd0);
    checkOutput("midRstMode", 32'(bus.mode_vec), 32'd0);
    bus.en = 1'b0;
    bus.pbit_in = '0;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    applyStimulus(2, 1, 1'b0);
    checkResult("afterRst", 9 + BURN_MODEL);
    acceptResult(1'b0);

    $display("[TB] ones only in the first two qualified samples");
    applyStimulus(3, 1, 1'b0);
    checkResult("burnIn", 9 + BURN_MODEL);
    acceptResult(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/pbit_sampler.md
PBIT_SAMPLER -- requirements
Module: pbit_sampler

Interface
REQ-001 SHALL have parameter NBITS, default 8, number of p-bits observed in parallel.
REQ-002 SHALL have parameter WIN_LOG2, default 10, giving a window of 2^WIN_LOG2 qualified samples.
REQ-003 SHALL have parameter BURN_IN, default 16, qualified samples discarded before accumulation (used only when the burn-in macro is defined).
REQ-004 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-005 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  request to begin a sampling run; honoured only in IDLE.
REQ-007 SHALL have port en  input  1  sample qualifier, the same strobe that advances the p-bits.
REQ-008 SHALL have port pbit_in  input  NBITS  current p-bit states, bit i from p-bit i.
REQ-009 SHALL have port busy  output  1  high in SETTLE and ACCUM.
REQ-010 SHALL have port res_valid  output  1  result available; high only in HOLD.
REQ-011 SHALL have port res_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port ones_cnt  output  NBITS*(WIN_LOG2+1)  packed per-bit ones counts, field i at bits [i*(WIN_LOG2+1) +: WIN_LOG2+1].
REQ-013 SHALL have port mode_vec  output  NBITS  per-bit majority state of the window.

Function
REQ-014 SHALL implement FSM states IDLE, SETTLE, ACCUM and HOLD.
REQ-015 IDLE SHALL go to SETTLE (macro defined, BURN_IN>0) or ACCUM on start=1, with busy=1 on the next cycle.
REQ-016 SETTLE SHALL count qualified cycles (en=1) and go to ACCUM after BURN_IN of them; pbit_in is ignored in SETTLE.
REQ-017 On entry to ACCUM, all counters SHALL be zero.
REQ-018 In ACCUM, on each edge with en=1, count i SHALL increment when pbit_in[i]=1.
REQ-019 With en=0, no counter or sample index SHALL change.
REQ-020 After exactly 2^WIN_LOG2 qualified samples, the FSM SHALL enter HOLD on the next edge, with res_valid=1 and busy=0.
REQ-021 Count width SHALL be WIN_LOG2+1, so an all-ones window (2^WIN_LOG2) is representable with no wrap.
REQ-022 mode_vec[i] SHALL equal 1 when count_i >= 2^(WIN_LOG2-1); a tie resolves to 1.
REQ-023 ones_cnt and mode_vec SHALL be registered and held stable throughout HOLD.
REQ-024 HOLD SHALL go to IDLE on the edge with res_ready=1; res_valid SHALL fall in the following cycle.
REQ-025 start SHALL be ignored outside IDLE, including in the accept cycle of HOLD.
REQ-026 res_ready outside HOLD SHALL have no effect.
REQ-027 ones_cnt and mode_vec SHALL retain the last result in IDLE until the next run enters ACCUM.

Reset
REQ-028 RST=0 SHALL at any time force IDLE, busy=0, res_valid=0, ones_cnt=0, mode_vec=0 and all internal counters to 0.
REQ-029 A run interrupted by reset SHALL be discarded; the next start SHALL begin a fresh run.

Configuration
REQ-030 The macro PBIT_SAMPLER_BURNIN_EN SHALL control burn-in: when defined, SETTLE and its counter exist and BURN_IN applies.
REQ-031 When PBIT_SAMPLER_BURNIN_EN is undefined, SETTLE SHALL be absent, IDLE SHALL go straight to ACCUM, and BURN_IN SHALL be ignored.

Structure
REQ-032 The state enumeration and count-width helper (WIN_LOG2+1) SHALL live in a shared package, pbit_pkg.
REQ-033 The per-bit counter with clear, increment and hold SHALL be one sub-module, pbit_ones_counter, instantiated NBITS times.

Verification (NBITS=4, WIN_LOG2=3, BURN_IN=2)
REQ-034 Macro undefined, en=1, pbit_in=4'b1010 constant, start pulse -> res_valid 9 cycles after start; counts {bit3..0}={8,0,8,0}; mode_vec=4'b1010.
REQ-035 Macro undefined, en high every other cycle, pbit_in=4'b1010 -> window takes 16 cycles; same counts and mode_vec as REQ-034.
REQ-036 Macro undefined, bit0 alternating 1/0, other bits 0 -> count0=4 (tie), mode_vec=4'b0001.
REQ-037 res_ready low for 5 cycles in HOLD, start pulsed meanwhile -> outputs stable, no new run; res_ready=1 -> IDLE, res_valid=0 next cycle.
REQ-038 RST low after 3 ACCUM samples -> busy=0, ones_cnt=0; new start with pbit_in=4'b1111 -> all counts 8.
REQ-039 Macro defined, pbit_in=4'b1111 for the first 2 qualified samples, then 4'b0000 -> all counts 0; same stimulus with macro undefined -> all counts 2.
